// File: rtl/tick_bcd_counter_if.sv
// tick_bcd_counter_if: divided-clock input, count controls and BCD/status outputs.
interface tick_bcd_counter_if;
  logic       clk_div_in;
  logic       en;
  logic       clear;
  logic       tick;
  logic [3:0] count_ones;
  logic [3:0] count_tens;
  logic       wrap;
  logic       stall;
  modport master (output clk_div_in, en, clear, input tick, count_ones, count_tens, wrap, stall);
  modport slave  (input clk_div_in, en, clear, output tick, count_ones, count_tens, wrap, stall);
endinterface

// File: rtl/tick_bcd_counter.sv
// tick_bcd_counter: edge-detects a divided clock as data and counts ticks in two BCD digits.
// Optional stall watchdog enabled by defining TICK_WATCHDOG_EN.
module tick_bcd_counter #(
  parameter int MAX_COUNT   = 59,
  parameter int WDOG_CYCLES = 32
) (
  input logic clk,
  input logic reset,
  tick_bcd_counter_if.slave bus
);
  localparam logic [3:0] max_t = 4'(MAX_COUNT / 10);
  localparam logic [3:0] max_o = 4'(MAX_COUNT % 10);
  logic s1, s2, det, inc, at_max;
  assign det    = s1 & ~s2;
  assign inc    = det & bus.en & ~bus.clear;
  assign at_max = bus.count_tens == max_t && bus.count_ones == max_o;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1             <= 1'b0;
      s2             <= 1'b0;
      bus.tick       <= 1'b0;
      bus.count_ones <= 4'd0;
      bus.count_tens <= 4'd0;
      bus.wrap       <= 1'b0;
    end else begin
      s1       <= bus.clk_div_in;
      s2       <= s1;
      bus.tick <= det;
      bus.wrap <= inc & at_max;
      if (bus.clear) begin
        bus.count_ones <= 4'd0;
        bus.count_tens <= 4'd0;
      end else if (inc) begin
        bus.count_ones <= (at_max || bus.count_ones == 4'd9) ? 4'd0 : bus.count_ones + 4'd1;
        bus.count_tens <= at_max ? 4'd0 : bus.count_ones == 4'd9 ? bus.count_tens + 4'd1 : bus.count_tens;
      end
    end
  end
`ifdef TICK_WATCHDOG_EN
  logic [7:0] wd, wd_nx;
  assign wd_nx = det ? 8'd0 : wd == 8'(WDOG_CYCLES) ? wd : wd + 8'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd        <= 8'd0;
      bus.stall <= 1'b0;
    end else begin
      wd        <= wd_nx;
      bus.stall <= wd_nx == 8'(WDOG_CYCLES);
    end
  end
`else
  assign bus.stall = 1'b0;
`endif
endmodule

// File: doc/tick_bcd_counter.md
# tick_bcd_counter

Downstream consumer of the divide-by-12 clock-divider output. It samples the divided clock as a data signal in the `clk` domain and turns each rising edge into a one-cycle `tick` strobe. It counts those ticks in a two-digit BCD counter that wraps at `MAX_COUNT`. An optional watchdog flags a stalled divider, so the divided signal never drives a clock pin.

## Interface
- `MAX_COUNT`, default 59: terminal decimal count; legal range 1..99; the counter wraps to 00 after reaching it.
- `WDOG_CYCLES`, default 32: number of `clk` cycles without a detected edge before `stall` asserts; legal range 2..255.
- `clk`  in  1: system clock; the only clock in the block.
- `reset`  in  1: asynchronous, active-high; clock `clk`.
- `clk_div_in`  in  1: divided clock from the divider, synchronous to `clk`, used as data.
- `en`  in  1: count enable; edges detected while `en`=0 are dropped, not queued.
- `clear`  in  1: synchronous clear of the BCD count.
- `tick`  out  1: one-cycle strobe per detected rising edge of `clk_div_in`, independent of `en`.
- `count_ones`  out  4: BCD units digit, 0..9.
- `count_tens`  out  4: BCD tens digit, 0..9.
- `wrap`  out  1: one-cycle pulse when the count goes from `MAX_COUNT` to 00.
- `stall`  out  1: watchdog flag; tied to 0 when the watchdog is compiled out.

## Operation
- Sampling:
  - `s1` <= `clk_div_in` every edge; `s2` <= `s1`.
  - `edge` = `s1` & ~`s2`, combinational and internal.
- Registered on every edge:
  - `tick` <= `edge`.
  - If `edge` & `en` & ~`clear`, the BCD count increments. The new count is visible in the same cycle as `tick`.
- Increment rules:
  - ones < 9: ones+1.
  - ones = 9: ones = 0 and tens+1.
  - {tens,ones} == `MAX_COUNT` (tens = `MAX_COUNT`/10, ones = `MAX_COUNT`%10): both digits go to 0 and `wrap` <= 1.
  - Digits never leave 0..9.
- `wrap` is 0 on every edge where no wrap occurs.
- `clear`=1 forces both digits to 0 and `wrap` to 0 on that edge.
  - `clear` wins over a simultaneous `edge`; that edge is not counted.
  - `tick` still fires for that edge.
- `en`=0 freezes the count; `tick` continues.
- Reset values: `s1`=`s2`=0, `tick`=0, `count_ones`=`count_tens`=0, `wrap`=0, `stall`=0, watchdog counter 0.
- A `clk_div_in` level that is high when reset is released produces one `tick` two edges later. This happens because `s2` resets to 0.
- Reset asserted mid-count clears all state immediately and asynchronously. No pending tick survives.

## Timing
- Latency: `clk_div_in` first sampled high at edge k leads to `tick`=1, and the updated count, during the cycle after edge k+1. This is two edges, and `tick` lasts exactly one cycle.
- `wrap` coincides with the `tick` cycle that carries the 00 count.
- Throughput:
  - One tick per input rising edge, for any input high/low time of at least 1 cycle.
  - A divider period of 12 gives one tick every 12 cycles.
- `clear` and `en` are sampled at the same edge as `edge`. Neither has pipeline delay.

## Configuration
- Macro `TICK_WATCHDOG_EN` defined:
  - An 8-bit cycle counter resets to 0 on `edge` and otherwise increments, saturating at `WDOG_CYCLES`.
  - `stall` is registered, =1 while the counter == `WDOG_CYCLES`.
  - `stall` returns to 0 on the edge where `edge`=1, i.e. in the same cycle `tick` asserts.
  - The watchdog is unaffected by `en` and `clear`.
- Macro not defined: no watchdog logic is generated and `stall` is constant 0.

## Test plan
- Reset release, `clk_div_in` period 12, `en`=1, `MAX_COUNT`=59 -> `tick` 1-cycle pulses 12 cycles apart; count 00,01,…,09,10 (tens=1, ones=0) after the 10th tick.
- 60 ticks with `MAX_COUNT`=59 -> 59th tick shows 59; 60th tick shows 00 with `wrap`=1 for that one cycle only.
- `clear`=1 on the same edge as a tick at count 23 -> count 00, `tick`=1, `wrap`=0; the next tick gives 01.
- `en`=0 across 3 ticks at count 07 -> `tick` pulses 3 times, count stays 07; after `en`=1 the next tick gives 08.
- Reset asserted mid-period at count 45 -> all outputs 0 asynchronously; after release, first tick gives count 01.
- `TICK_WATCHDOG_EN`, `WDOG_CYCLES`=32, hold `clk_div_in`=0 -> `stall`=1 at 32 cycles after the last edge; next rising edge -> `stall`=0 in the `tick` cycle. Without the macro, `stall` stays 0.
